ak4619_tdm: RTL and testbench
=============================

Name: ak4619_tdm

Overview:
- Parametrised serial-audio master for the AK4619 codec. It replaces the fixed 2-channel, 16-bit, free-running interface with configurable channel count, sample width, slot width and bit-clock ratio.
- Generates BICK and LRCK from the single system clock, shifts DAC samples out on SDIN1 and captures ADC samples from SDOUT1.
- Faces the fabric with a per-frame valid/ready DAC port, a per-frame ADC strobe and underrun reporting. Sits between the codec pins and the sample-processing core.

Parameters:
- W, 16: sample width in bits. 1 <= W <= SLOT_BITS.
- CHANNELS, 4: channels per direction per frame. Even and >= 2; 2 gives stereo, 4/8 give TDM.
- SLOT_BITS, 32: BICK periods per channel slot.
- CLK_PER_BICK, 4: clk cycles per BICK period. Even and >= 2.

Ports:
- clk  in  1  system clock. All logic runs on its rising edge; this clock also drives mclk.
- rst_n  in  1  synchronous active-low reset.
- mclk  out  1  equal to clk.
- bick  out  1  codec bit clock (registered).
- lrck  out  1  codec frame clock (registered).
- sdin1  out  1  serial DAC data to codec (registered).
- sdout1  in  1  serial ADC data from codec.
- dac_data  in  CHANNELS*W  DAC frame; channel k occupies bits [k*W +: W].
- dac_valid  in  1  dac_data valid.
- dac_ready  out  1  holding register empty.
- adc_data  out  CHANNELS*W  last complete ADC frame, packed the same way as dac_data.
- adc_valid  out  1  one-cycle pulse when adc_data updates.
- underrun  out  1  sticky flag: a frame started with no DAC data.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (rst_n=0 at a clk edge): all counters go to 0, holding register goes empty, transmit bank goes to 0.
  - Output values during reset: bick=0, lrck=0, sdin1=0, adc_data=0, adc_valid=0, dac_ready=1, underrun=0.
  - Reset mid-frame aborts the frame immediately and emits no partial adc_valid.
- Phase counter p counts 0..CLK_PER_BICK-1 and wraps.
  - bick is 0 for p < CLK_PER_BICK/2 and 1 otherwise.
  - The "fall" cycle is p==0; the "rise" cycle is p==CLK_PER_BICK/2.
- Bit counter b counts 0..SLOT_BITS-1 and slot counter s counts 0..CHANNELS-1. Both advance on each fall; b wraps into s, and s wraps into a new frame.
  - The first fall after reset release is frame start, with b=0 and s=0.
- lrck is 0 for s < CHANNELS/2 and 1 otherwise. It changes on fall cycles only.
- Transmit is left-justified, MSB first.
  - On each fall cycle, sdin1 takes transmit-bank channel s, bit W-1-b, when b < W.
  - When b >= W, sdin1 takes 0.
- Receive: on each rise cycle with b < W, sdout1 is stored into capture channel s, bit W-1-b. Bits with b >= W are ignored.
- Frame start (fall cycle with b=0, s=0):
  - If the holding register is full, its contents move to the transmit bank and the holding register becomes empty.
  - If it is empty, the transmit bank keeps the previous frame's samples (repeat) and underrun is set.
  - From the second frame start onward, adc_data takes the capture bank and adc_valid pulses for this one cycle.
- DAC handshake: dac_ready = holding register empty. A word transfers when dac_valid && dac_ready.
  - A word accepted on a frame-start cycle is not used for that frame. The frame underruns and the word plays next frame; there is no bypass.
- underrun_clr and a new underrun event in the same cycle: underrun stays set (set wins).
- Latency:
  - A word accepted in frame N-1 is transmitted in frame N.
  - ADC bits sampled in frame N appear on adc_data at the start of frame N+1.
- Default rates at 12 MHz clk: frame = CHANNELS*SLOT_BITS*CLK_PER_BICK clk = 512 cycles, giving 23.4375 kHz. CHANNELS=2 gives 46.875 kHz.

Optional Feature:
- Macro: AK4619_LOOPBACK_EN.
- When defined: an extra input port loopback (1 bit) exists. While loopback=1:
  - frame start loads the transmit bank from the just-completed capture bank;
  - dac_ready is forced to 0;
  - underrun is never set.
- When undefined: the port is absent and the behaviour is exactly as described above.

Decomposition:
- Package ak4619_pkg holds:
  - default parameter constants;
  - a clog2 function for counter widths;
  - a channel slice helper (offset = k*W).
- One natural sub-module, ak4619_tdm_clkgen:
  - owns p, b and s;
  - drives bick and lrck;
  - emits one-cycle fall, rise and frame_start strobes plus the current b and s.

Test Plan:
1. Reset release with defaults -> bick period 4 clk, lrck period 512 clk (low for the first 256), sdin1=0, dac_ready=1.
2. Accept dac_data {ch3..ch0} = {16'h0004, 16'h0003, 16'h0002, 16'h8001} before the 2nd frame start -> slot 0 on sdin1 is 1000_0000_0000_0001 followed by 16 zeros; slot 3 carries 0x0004. dac_ready drops to 0 and returns to 1 at frame start.
3. Drive sdout1 so the codec sends 0xA5A5 in slot 1 and 0x1234 in slot 2 -> at the next frame start adc_data[31:16]=16'hA5A5 and adc_data[47:32]=16'h1234, with a one-cycle adc_valid.
4. No dac_valid for one frame -> previous samples repeat on sdin1 and underrun=1. underrun_clr clears it; underrun_clr asserted on a frame-start underrun cycle leaves it at 1.
5. Assert rst_n=0 mid-slot 2 for one cycle -> all outputs return to reset values the next cycle, no adc_valid, and framing restarts at s=0.
6. CHANNELS=2, W=24, CLK_PER_BICK=2 -> frame 128 clk; a 24-bit ADC round-trip matches bit-exactly. With AK4619_LOOPBACK_EN and loopback=1, sdin1 in frame N+1 equals sdout1 from frame N.

Source files
------------

// File: rtl/ak4619_pkg.sv
// ak4619_pkg: default parameters and sizing/slicing helpers for the AK4619 TDM master
package ak4619_pkg;
  localparam int DEF_W = 16;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_CLK_PER_BICK = 4;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/ak4619_tdm_clkgen.sv
// ak4619_tdm_clkgen: phase/bit/slot counters, registered BICK/LRCK and fall/rise/frame strobes
module ak4619_tdm_clkgen
  import ak4619_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int CLK_PER_BICK = DEF_CLK_PER_BICK
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           bick,
  output logic                           lrck,
  output logic                           fall,
  output logic                           rise,
  output logic                           frame_start,
  output logic [clog2(SLOT_BITS)-1:0]    b,
  output logic [clog2(CHANNELS)-1:0]     s
);
  localparam int PW = clog2(CLK_PER_BICK);
  localparam int BW = clog2(SLOT_BITS);
  localparam int SW = clog2(CHANNELS);
  logic [PW-1:0] p, p_n;
  logic [BW-1:0] b_n;
  logic [SW-1:0] s_n;
  logic wrap, b_last;
  always_comb begin
    wrap = p == PW'(CLK_PER_BICK - 1);
    b_last = b == BW'(SLOT_BITS - 1);
    p_n = wrap ? '0 : p + 1'b1;
    b_n = wrap ? (b_last ? '0 : b + 1'b1) : b;
    s_n = wrap && b_last ? (s == SW'(CHANNELS - 1) ? '0 : s + 1'b1) : s;
  end
  // bick/lrck are registered from next-state so they line up with the current p and s
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
      b <= '0;
      s <= '0;
      bick <= 1'b0;
      lrck <= 1'b0;
    end else begin
      p <= p_n;
      b <= b_n;
      s <= s_n;
      bick <= p_n >= PW'(CLK_PER_BICK / 2);
      lrck <= s_n >= SW'(CHANNELS / 2);
    end
  end
  assign fall = p == '0;
  assign rise = p == PW'(CLK_PER_BICK / 2);
  assign frame_start = fall && b == '0 && s == '0;
endmodule

// File: rtl/ak4619_tdm.sv
// ak4619_tdm: AK4619 serial-audio master with TDM framing, DAC holding register and ADC capture.
// Define AK4619_LOOPBACK_EN to add a loopback input that replays captured frames on the DAC.
module ak4619_tdm
  import ak4619_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int CLK_PER_BICK = DEF_CLK_PER_BICK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    mclk,
  output logic                    bick,
  output logic                    lrck,
  output logic                    sdin1,
  input  logic                    sdout1,
  input  logic [CHANNELS*W-1:0]   dac_data,
  input  logic                    dac_valid,
  output logic                    dac_ready,
  output logic [CHANNELS*W-1:0]   adc_data,
  output logic                    adc_valid,
  output logic                    underrun,
  input  logic                    underrun_clr
`ifdef AK4619_LOOPBACK_EN
  ,
  input  logic                    loopback
`endif
);
  localparam int N = CHANNELS * W;
  localparam int IW = clog2(N);
  localparam int BW = clog2(SLOT_BITS);
  localparam int SW = clog2(CHANNELS);
  logic fall, rise, frame_start, full, seen, lb, accept, in_word, uflow;
  logic [BW-1:0] b;
  logic [SW-1:0] s;
  logic [IW-1:0] idx;
  logic [N-1:0] hold, bank, bank_n, cap;
`ifdef AK4619_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif
  ak4619_tdm_clkgen #(
    .CHANNELS(CHANNELS),
    .SLOT_BITS(SLOT_BITS),
    .CLK_PER_BICK(CLK_PER_BICK)
  ) u_clkgen (
    .clk(clk),
    .rst_n(rst_n),
    .bick(bick),
    .lrck(lrck),
    .fall(fall),
    .rise(rise),
    .frame_start(frame_start),
    .b(b),
    .s(s)
  );
  assign mclk = clk;
  assign dac_ready = !full && !lb;
  // bank_n lets the first bit of a frame come from the freshly loaded samples
  always_comb begin
    accept = dac_valid && dac_ready;
    in_word = int'(b) < W;
    idx = IW'(slice_lo(int'(s), W) + W - 1 - int'(b));
    uflow = frame_start && !full && !lb;
    bank_n = !frame_start ? bank : lb ? cap : full ? hold : bank;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      full <= 1'b0;
      bank <= '0;
      cap <= '0;
      sdin1 <= 1'b0;
      adc_data <= '0;
      adc_valid <= 1'b0;
      underrun <= 1'b0;
      seen <= 1'b0;
    end else begin
      bank <= bank_n;
      full <= accept || (full && !(frame_start && !lb));
      if (accept) hold <= dac_data;
      if (fall) sdin1 <= in_word && bank_n[idx];
      if (rise && in_word) cap[idx] <= sdout1;
      adc_valid <= frame_start && seen;
      if (frame_start && seen) adc_data <= cap;
      if (frame_start) seen <= 1'b1;
      underrun <= uflow || (underrun && !underrun_clr);
    end
  end
endmodule

// File: tb/tb_ak4619_tdm.sv
// tb_ak4619_tdm: scoreboard bench for ak4619_tdm in a 4ch/16b/4clk and a 2ch/24b/2clk configuration
module tb_ak4619_tdm;
  logic clk = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CH = g == 0 ? 4 : 2;
    localparam int W = g == 0 ? 16 : 24;
    localparam int SB = 32;
    localparam int CPB = g == 0 ? 4 : 2;
    localparam int N = CH * W;
    localparam int FR = CH * SB * CPB;
    logic rst_n = 1'b0, sdout1 = 1'b0, dac_valid = 1'b0, underrun_clr = 1'b0, lb = 1'b0, done = 1'b0;
    logic [N-1:0] dac_data = '0;
    logic mclk, bick, lrck, sdin1, dac_ready, adc_valid, underrun;
    logic [N-1:0] adc_data;
    int t = 0, adc_n = 0, tx_n = 0;
    logic full_m = 1'b0, und_m = 1'b0;
    logic [N-1:0] hold_m = '0, bank_m = '0, src = '0;
    logic [N-1:0] txq[$];
    logic [N-1:0] adcq[$];
    logic [SB-1:0] rx[CH];

    ak4619_tdm #(.W(W), .CHANNELS(CH), .SLOT_BITS(SB), .CLK_PER_BICK(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mclk(mclk),
      .bick(bick),
      .lrck(lrck),
      .sdin1(sdin1),
      .sdout1(sdout1),
      .dac_data(dac_data),
      .dac_valid(dac_valid),
      .dac_ready(dac_ready),
      .adc_data(adc_data),
      .adc_valid(adc_valid),
      .underrun(underrun),
      .underrun_clr(underrun_clr)
`ifdef AK4619_LOOPBACK_EN
      ,
      .loopback(lb)
`endif
    );

    // codec + fabric model: t is the clk cycle index since reset release
    always @(negedge clk) begin
      int ph, bn, sl, fr;
      logic acc, uf;
      logic [SB-1:0] e;
      logic [N-1:0] w;
      if (!rst_n) begin
        t = 0;
        full_m = 1'b0;
        und_m = 1'b0;
        hold_m = '0;
        bank_m = '0;
        src = '0;
        txq.delete();
        adcq.delete();
      end else begin
        ph = t % CPB;
        bn = (t / CPB) % SB;
        sl = (t / (CPB * SB)) % CH;
        fr = t / FR;
        if (t == 0) begin
          check("rst_sdin1", 64'(sdin1), 64'(0));
          check("rst_adc_data", 64'(adc_data), 64'(0));
          check("mclk", 64'(mclk), 64'(clk));
        end
        check("bick", 64'(bick), 64'(ph >= CPB / 2));
        check("lrck", 64'(lrck), 64'(sl >= CH / 2));
        check("dac_ready", 64'(dac_ready), 64'(!full_m && !lb));
        check("underrun", 64'(underrun), 64'(und_m));
        if (adc_valid) begin
          if (adcq.size() == 0) check("adc_valid_spurious", 64'(adc_valid), 64'(0));
          else begin
            check("adc_data", 64'(adc_data), 64'(adcq.pop_front()));
            adc_n++;
          end
        end
        acc = dac_valid && !full_m && !lb;
        uf = 1'b0;
        if (t % FR == 0) begin
          if (fr > 0) adcq.push_back(src);
          if (lb) bank_m = src;
          else if (full_m) begin
            bank_m = hold_m;
            full_m = 1'b0;
          end else uf = 1'b1;
          txq.push_back(bank_m);
          src = N'({$urandom(), $urandom()});
          if (g == 0 && fr == 2) begin
            src[31:16] = 16'hA5A5;
            src[47:32] = 16'h1234;
          end
        end
        und_m = uf || (und_m && !underrun_clr);
        if (acc) begin
          hold_m = dac_data;
          full_m = 1'b1;
        end
        if (ph == 0) begin
          w = src >> (sl * W + W - 1 - bn);
          sdout1 = bn < W ? w[0] : 1'($urandom());
        end
        if (ph == CPB / 2) begin
          rx[sl] = {rx[sl][SB-2:0], sdin1};
          if (sl == CH - 1 && bn == SB - 1) begin
            if (txq.size() == 0) check("tx_queue", 64'(txq.size()), 64'(1));
            else begin
              w = txq.pop_front();
              for (int k = 0; k < CH; k++) begin
                e = SB'(W'(w >> (k * W))) << (SB - W);
                check("sdin1_slot", 64'(rx[k]), 64'(e));
              end
              tx_n++;
            end
          end
        end
        t++;
      end
    end

    task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic wait_frame_start();
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FR && !hit; i++) begin
        @(posedge clk);
        #1;
        hit = rst_n && (t % FR == 0);
      end
      check("frame_start_wait", 64'(hit), 64'(1));
    endtask

    task automatic send(input logic [N-1:0] d);
      bit ok = 1'b0;
      dac_data = d;
      dac_valid = 1'b1;
      for (int i = 0; i < 4 * FR && !ok; i++) begin
        @(negedge clk);
        ok = dac_ready;
      end
      check("send_accept", 64'(ok), 64'(1));
      @(posedge clk);
      #1;
      dac_valid = 1'b0;
    endtask

    initial begin
      wait_cycles(3);
      rst_n = 1'b1;
      if (g == 0) begin
        wait_cycles(20);
        send(N'({16'h0004, 16'h0003, 16'h0002, 16'h8001}));
        wait_cycles(30);
        underrun_clr = 1'b1;
        wait_cycles(1);
        underrun_clr = 1'b0;
        wait_frame_start();
        wait_cycles(40);
        send(N'({$urandom(), $urandom()}));
        wait_frame_start();
        wait_frame_start();
        underrun_clr = 1'b1;
        wait_cycles(1);
        underrun_clr = 1'b0;
        wait_cycles(100);
        underrun_clr = 1'b1;
        wait_cycles(1);
        underrun_clr = 1'b0;
        send(N'({$urandom(), $urandom()}));
        wait_frame_start();
        wait_cycles(2 * SB * CPB + 37);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        send(N'({$urandom(), $urandom()}));
        wait_frame_start();
        wait_frame_start();
      end else begin
        wait_cycles(10);
        for (int f = 0; f < 4; f++) begin
          if (f != 2) send(N'({$urandom(), $urandom()}));
          wait_frame_start();
        end
`ifdef AK4619_LOOPBACK_EN
        lb = 1'b1;
        repeat (3) wait_frame_start();
        lb = 1'b0;
`endif
        wait_frame_start();
      end
      wait_cycles(10);
      check("adc_frames_seen", 64'(adc_n >= 2), 64'(1));
      check("tx_frames_seen", 64'(tx_n >= 3), 64'(1));
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(cfg[0].done && cfg[1].done); i++) @(posedge clk);
    check("finish_timeout", 64'(cfg[0].done && cfg[1].done), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
